fetch_decode_latch: RTL
=======================

// Module: fetch_decode_latch
// PURPOSE
//  IF/ID pipeline register of the 5-stage core. Captures fetched instruction and PC+2,
//  presents decoded source-register fields to the hazard unit, honours hazard-unit
//  stalls (insert_nop), squashes wrong-path fetches after a taken branch/jump, blocks
//  fetches past HALT, and keeps stall/flush event counters for debug.
// PARAMETERS
//  NOP_INSTR     16'h0800  encoding loaded on squash (opcode 5'b00001)
//  FLUSH_CYCLES  1         cycles squashed per flush, incl. flush cycle (1..7)
//  CNT_W         16        width of event counters
// PORTS
//  clk          in   1      core clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  if_instr     in   16     instruction from fetch
//  if_pc_inc    in   16     PC+2 from fetch
//  if_valid     in   1      fetch output valid this cycle
//  insert_nop   in   1      stall request from hazard unit
//  flush        in   1      taken branch/jump resolved in execute
//  fd_instr     out  16     registered instruction to decode
//  fd_pc_inc    out  16     registered PC+2
//  fd_valid     out  1      fd_instr is a real, non-squashed instruction
//  fd_opcode    out  5      fd_instr[15:11]
//  fd_rs        out  3      fd_instr[10:8]
//  fd_rt        out  3      fd_instr[7:5]
//  pc_hold      out  1      to fetch: hold PC this cycle
//  halt_seen    out  1      valid HALT resides in/has passed IF/ID
//  stall_count  out  CNT_W  cycles held due to insert_nop
//  flush_count  out  CNT_W  flush events accepted
// BEHAVIOUR
//  Reset (rst=1 at edge): fd_instr=NOP_INSTR, fd_pc_inc=0, fd_valid=0, halt_seen=0,
//   squash counter=0, both counters=0. rst overrides every other input.
//  Per-edge priority: rst > flush > insert_nop > squash > halt block > load.
//  flush=1: fd_instr<=NOP_INSTR, fd_valid<=0, fd_pc_inc<=0, squash<=FLUSH_CYCLES-1,
//   halt_seen<=0 (wrong-path HALT discarded), flush_count++ ; flush beats insert_nop.
//  insert_nop=1 (no flush): all IF/ID regs and squash counter hold; stall_count++.
//  squash>0 (no flush/stall): load NOP, fd_valid<=0, squash<=squash-1.
//  halt_seen=1 (no flush/stall/squash): load NOP, fd_valid<=0; stays until flush/rst.
//  Load: fd_instr<=if_instr, fd_pc_inc<=if_pc_inc, fd_valid<=if_valid;
//   if_valid=0 loads NOP_INSTR. If loaded opcode==5'b00000 and if_valid -> halt_seen<=1.
//  pc_hold = insert_nop & ~flush | halt_seen (combinational, 0 during rst).
//  fd_opcode/fd_rs/fd_rt: pure slices of fd_instr, no extra latency.
//  Latency: instruction appears on fd_* exactly 1 cycle after fetch, +1 per stall cycle.
//  Counters saturate at all-ones; no wrap. Both may not increment in same cycle.
//  Reset mid-stall or mid-squash: state returns to reset values next edge, no residue.
// TESTING
//  rst 2 cyc, then if_instr=16'hC123,if_pc_inc=2,if_valid=1 -> next cyc fd_instr=C123,
//   fd_valid=1, fd_rs=3'b001, fd_rt=3'b001, fd_opcode=5'b11000.
//  insert_nop=1 for 3 cyc with fd_instr=C123 while if_instr changes -> fd_instr holds
//   C123, pc_hold=1 all 3 cyc, stall_count=3.
//  flush & insert_nop same cyc -> fd_instr=16'h0800, fd_valid=0, flush_count=1,
//   stall_count unchanged; FLUSH_CYCLES=3 -> next 2 loads squashed, 3rd loads fetch.
//  load HALT 16'h0000 valid -> halt_seen=1, pc_hold=1, later fetches give fd_valid=0;
//   flush -> halt_seen=0 and loading resumes after squash window.
//  force stall_count to all-ones-1, stall 3 cyc -> saturates at all-ones.
//  assert rst during squash window and during stall -> all outputs at reset values.

Source files
------------

// File: rtl/fetch_decode_latch.sv
// IF/ID pipeline register for the 5-stage core.
// Captures the fetched instruction and its PC+2, exposes decoded source-register
// fields to the hazard unit, holds on hazard stalls, squashes wrong-path fetches
// after a taken branch/jump, blocks further fetches once a HALT has been latched,
// and keeps saturating stall/flush event counters for debug.
//
// Handshake semantics (fetch -> IF/ID -> decode):
//   if_valid marks if_instr/if_pc_inc as a real fetched instruction this cycle.
//   insert_nop acts as the "not ready" from downstream: while it is high (and no
//   flush is present) nothing is consumed, the register holds, and pc_hold tells
//   fetch to keep presenting the same PC. A fetch is consumed on every edge where
//   neither rst, flush, insert_nop, an active squash nor a latched HALT blocks it.
//   fd_valid marks fd_instr as a real, non-squashed instruction for decode.
module fetch_decode_latch #(
    parameter logic [15:0] NOP_INSTR    = 16'h0800,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      if_instr,
    input  logic [15:0]      if_pc_inc,
    input  logic             if_valid,
    input  logic             insert_nop,
    input  logic             flush,
    output logic [15:0]      fd_instr,
    output logic [15:0]      fd_pc_inc,
    output logic             fd_valid,
    output logic [4:0]       fd_opcode,
    output logic [2:0]       fd_rs,
    output logic [2:0]       fd_rt,
    output logic             pc_hold,
    output logic             halt_seen,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Opcode that identifies a HALT instruction.
    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    // Number of loads squashed after the flush cycle itself.
    localparam logic [2:0] SQUASH_INIT = 3'(FLUSH_CYCLES - 1);

    // Registered IF/ID state.
    logic [15:0]      instr_q;
    logic [15:0]      pc_inc_q;
    logic             valid_q;
    logic             halt_q;
    logic [2:0]       squash_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Next-state values.
    logic [15:0]      instr_d;
    logic [15:0]      pc_inc_d;
    logic             valid_d;
    logic             halt_d;
    logic [2:0]       squash_d;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_d;

    // Decoded events for this cycle.
    logic             stall_evt;
    logic             squash_active;
    logic [15:0]      load_instr;
    logic             load_is_halt;

    // A stall only counts when a flush is not overriding it.
    assign stall_evt     = insert_nop & ~flush;
    assign squash_active = (squash_q != 3'd0);

    // Invalid fetch slots enter the pipe as the NOP encoding.
    assign load_instr    = if_valid ? if_instr : NOP_INSTR;
    assign load_is_halt  = if_valid & (if_instr[15:11] == HALT_OPCODE);

    // Next-state selection in priority order: flush > stall > squash > halt > load.
    always_comb begin
        instr_d  = instr_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        halt_d   = halt_q;
        squash_d = squash_q;

        if (flush) begin
            // Wrong-path contents, including any HALT, are discarded.
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
            halt_d   = 1'b0;
            squash_d = SQUASH_INIT;
        end else if (insert_nop) begin
            // Hold everything, including the squash countdown.
            instr_d  = instr_q;
            pc_inc_d = pc_inc_q;
            valid_d  = valid_q;
            halt_d   = halt_q;
            squash_d = squash_q;
        end else if (squash_active) begin
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
            squash_d = squash_q - 3'd1;
        end else if (halt_q) begin
            // Nothing past a HALT is allowed into decode until a flush.
            instr_d  = NOP_INSTR;
            pc_inc_d = 16'h0000;
            valid_d  = 1'b0;
        end else begin
            instr_d  = load_instr;
            pc_inc_d = if_pc_inc;
            valid_d  = if_valid;
            halt_d   = load_is_halt;
        end
    end

    // Saturating event counters; a flush cycle never counts as a stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // IF/ID register with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q  <= NOP_INSTR;
            pc_inc_q <= 16'h0000;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
            squash_q <= 3'd0;
        end else begin
            instr_q  <= instr_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
            squash_q <= squash_d;
        end
    end

    // Debug counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Fetch must hold its PC during a stall or once a HALT has been latched.
    assign pc_hold     = ~rst & (stall_evt | halt_q);

    assign fd_instr    = instr_q;
    assign fd_pc_inc   = pc_inc_q;
    assign fd_valid    = valid_q;
    assign halt_seen   = halt_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    // Source fields are straight slices so the hazard unit sees them immediately.
    assign fd_opcode   = instr_q[15:11];
    assign fd_rs       = instr_q[10:8];
    assign fd_rt       = instr_q[7:5];

endmodule
